// File: rtl/yubex_stopwatch_pkg.sv
// Shared constants for the yubex stopwatch tile: FSM encoding, segment codes,
// the BCD time record and its ripple-carry increment.
package yubex_stopwatch_pkg;

  localparam int CLK_FREQ_DEFAULT = 10000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_LAP  = 3'd2;
  localparam logic [2:0] ST_STOP = 3'd3;
  localparam logic [2:0] ST_FULL = 3'd4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [7:0] DISP_IDLE = 8'h40;
  localparam logic [7:0] DISP_FULL = 8'hF1;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam logic [15:0] TIME_MAX = 16'h5959;

  // One-second advance with ripple carry; callers never pass 59:59.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.s1 != 4'd9) begin
      n.s1 = t.s1 + 4'd1;
    end else begin
      n.s1 = 4'd0;
      if (t.s10 != 4'd5) begin
        n.s10 = t.s10 + 4'd1;
      end else begin
        n.s10 = 4'd0;
        if (t.m1 != 4'd9) begin
          n.m1 = t.m1 + 4'd1;
        end else begin
          n.m1  = 4'd0;
          n.m10 = t.m10 + 4'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] digit_of(input bcd_time_t t, input logic [1:0] sel);
    logic [3:0] d;
    case (sel)
      2'b00:   d = t.s1;
      2'b01:   d = t.s10;
      2'b10:   d = t.m1;
      default: d = t.m10;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/yubex_seg7_decoder.sv
// Combinational BCD to 7-segment decoder (bit0=a .. bit6=g, active-high);
// non-decimal inputs blank the display.
module yubex_seg7_decoder
  import yubex_stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/yubex_stopwatch.sv
// Count-up stopwatch tile on the 8-in/8-out pinout. Define YUBEX_STOPWATCH_LAP_EN
// to add the LAP state and lap-freeze registers.
module yubex_stopwatch
  import yubex_stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEFAULT
)
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [13:0] PRESC_MAX  = 14'(CLK_FREQ - 1);
  localparam logic [13:0] PRESC_HALF = 14'(CLK_FREQ / 2);

  logic       clk, rst, start_btn, lap_btn;
  logic [1:0] digit_sel;
  logic       unused_pins;

  assign clk         = io_in[0];
  assign rst         = io_in[1];
  assign start_btn   = io_in[2];
  assign lap_btn     = io_in[3];
  assign digit_sel   = io_in[5:4];
  assign unused_pins = &{1'b0, io_in[7:6]};

  logic ss_meta, ss_sync, ss_prev, lc_meta, lc_sync, lc_prev;
  logic ss_pulse, lc_pulse;
  logic [2:0] state, next_state;
  logic [13:0] presc;
  bcd_time_t tm;
  logic [1:0] sel_q;
  logic tick, counting, at_max;
  logic [3:0] digit;
  logic [6:0] seg;
  logic [7:0] disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      {ss_meta, ss_sync, ss_prev} <= 3'b000;
      {lc_meta, lc_sync, lc_prev} <= 3'b000;
      sel_q <= 2'b00;
    end else begin
      {ss_meta, ss_sync, ss_prev} <= {start_btn, ss_meta, ss_sync};
      {lc_meta, lc_sync, lc_prev} <= {lap_btn, lc_meta, lc_sync};
      sel_q <= digit_sel;
    end
  end

  assign ss_pulse = ss_sync & ~ss_prev;
  assign lc_pulse = lc_sync & ~lc_prev;
  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = counting && (presc == PRESC_MAX);
  assign at_max   = (tm == TIME_MAX);

  // start_stop always wins; a lap_clr pulse in the same cycle is dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (ss_pulse) next_state = ST_RUN;
      ST_RUN: begin
        if (ss_pulse)              next_state = ST_STOP;
        else if (tick && at_max)   next_state = ST_FULL;
`ifdef YUBEX_STOPWATCH_LAP_EN
        else if (lc_pulse)         next_state = ST_LAP;
`endif
      end
`ifdef YUBEX_STOPWATCH_LAP_EN
      ST_LAP: begin
        if (ss_pulse)              next_state = ST_STOP;
        else if (tick && at_max)   next_state = ST_FULL;
        else if (lc_pulse)         next_state = ST_RUN;
      end
`endif
      ST_STOP: begin
        if (ss_pulse)              next_state = ST_RUN;
        else if (lc_pulse)         next_state = ST_IDLE;
      end
      ST_FULL: if (lc_pulse) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // A tick is applied even when the same edge moves the FSM to STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      presc <= '0;
      tm    <= '0;
    end else begin
      state <= next_state;
      if (next_state == ST_IDLE) begin
        presc <= '0;
        tm    <= '0;
      end else begin
        if (counting) presc <= tick ? 14'd0 : presc + 14'd1;
        if (tick && !at_max) tm <= bcd_inc(tm);
      end
    end
  end

`ifdef YUBEX_STOPWATCH_LAP_EN
  bcd_time_t lap_tm;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_tm <= '0;
    end else if (state == ST_RUN && next_state == ST_LAP) begin
      lap_tm <= tm;
    end
  end

  assign digit = (state == ST_LAP) ? digit_of(lap_tm, sel_q) : digit_of(tm, sel_q);
`else
  assign digit = digit_of(tm, sel_q);
`endif

  yubex_seg7_decoder u_decoder (
    .bcd (digit),
    .seg (seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: disp <= DISP_IDLE;
        ST_RUN:  disp <= {presc < PRESC_HALF, seg};
        ST_LAP:  disp <= {1'b1, seg};
        ST_STOP: disp <= {1'b0, seg};
        ST_FULL: disp <= DISP_FULL;
        default: disp <= DISP_IDLE;
      endcase
    end
  end

  assign io_out = disp;

endmodule

// File: tb/tb_yubex_stopwatch.sv
// Scoreboard bench for yubex_stopwatch at CLK_FREQ=4: stimulus queues expected
// io_out values tagged with the clock edge they are due; a monitor compares them.
module tb_yubex_stopwatch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss = 1'b0;
   logic       lc = 1'b0;
   logic [1:0] sel = 2'b00;
   logic [7:0] io_in;
   logic [7:0] io_out;

   assign io_in = {2'b00, sel, lc, ss, rst, clk};

   yubex_stopwatch #(.CLK_FREQ(4)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [7:0] exp;
      logic [7:0] mask;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t monEntry;
   int   cyc = 0;
   int   checkCount = 0;
   int   passCount = 0;

   // cyc numbers rising edges; each entry is compared just after its edge.
   always @(posedge clk) begin
      #2;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         monEntry = sb.pop_front();
         checkCount++;
         if (monEntry.due == cyc && ((io_out & monEntry.mask) == monEntry.exp))
            passCount++;
         else
            $display("[TB] FAIL %s: edge %0d io_out=%02h required %02h (mask %02h, due edge %0d)",
                     monEntry.name, cyc, io_out, monEntry.exp, monEntry.mask, monEntry.due);
      end
   end

   // Queue an expected io_out value for the monitor to compare at its edge.
   task automatic checkOutput(input int due, input logic [7:0] exp, input string name);
      exp_t e;
      e.due  = due;
      e.exp  = exp;
      e.mask = 8'hFF;
      e.name = name;
      sb.push_back(e);
   endtask

   // Drive the button and digit-select inputs.
   task automatic applyStimulus(input logic s, input logic l, input logic [1:0] d);
      ss  = s;
      lc  = l;
      sel = d;
   endtask

   // Wait on falling edges until the edge counter reaches the target.
   task automatic gotoCycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // One-cycle button press.
   task automatic press(input logic s, input logic l);
      applyStimulus(s, l, sel);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, sel);
   endtask

   // Synchronous reset with a direct check of the zeroed output register.
   task automatic doReset();
      int r;
      r = cyc;
      applyStimulus(1'b0, 1'b0, 2'b00);
      rst = 1'b1;
      checkOutput(r + 1, 8'h00, "reset_zero");
      @(negedge clk);
      checkCount++;
      if (io_out === 8'h00)
         passCount++;
      else
         $display("[TB] FAIL reset_direct: io_out=%02h required 00", io_out);
      rst = 1'b0;
      checkOutput(r + 2, 8'h40, "reset_idle");
   endtask

   // Returns the edge at which the FSM enters RUN.
   task automatic startRun(output int t0);
      int c;
      c = cyc;
      press(1'b1, 1'b0);
      t0 = c + 3;
   endtask

   // Main stimulus sequence following the test plan.
   initial begin : stim
      int t0;
      int waitCycles;
      @(negedge clk);
      doReset();
      checkOutput(8, 8'h40, "idle_hold");

      gotoCycle(10);
      startRun(t0);
      checkOutput(t0 + 1,  8'hBF, "run_first");
      checkOutput(t0 + 17, 8'hE6, "four_dp_on");
      checkOutput(t0 + 19, 8'h66, "four_dp_off");
      checkOutput(t0 + 20, 8'h66, "four_dp_off2");
      checkOutput(t0 + 21, 8'hED, "five_dp_on");
      checkOutput(t0 + 40, 8'h6F, "nine");
      checkOutput(t0 + 41, 8'hBF, "carry_ones");
      checkOutput(t0 + 42, 8'hBF, "sel_latency");
      checkOutput(t0 + 43, 8'h06, "carry_tens");
      gotoCycle(t0 + 41);
      applyStimulus(1'b0, 1'b0, 2'b01);

      gotoCycle(t0 + 46);
      doReset();
      gotoCycle(cyc + 3);
      startRun(t0);
`ifdef YUBEX_STOPWATCH_LAP_EN
      checkOutput(t0 + 23, 8'hED, "lap_frozen");
      checkOutput(t0 + 26, 8'hED, "lap_frozen6");
      checkOutput(t0 + 31, 8'hED, "lap_frozen7");
      checkOutput(t0 + 33, 8'hED, "lap_frozen8");
`else
      checkOutput(t0 + 23, 8'h6D, "nolap_live5");
      checkOutput(t0 + 26, 8'hFD, "nolap_live6");
      checkOutput(t0 + 31, 8'h07, "nolap_live7");
      checkOutput(t0 + 33, 8'hFF, "nolap_live8");
`endif
      gotoCycle(t0 + 19);
      press(1'b0, 1'b1);
      gotoCycle(t0 + 30);
      press(1'b0, 1'b1);
      checkOutput(t0 + 34, 8'hFF, "lap_release8");
      checkOutput(t0 + 40, 8'h6F, "stop_nine");
      checkOutput(t0 + 50, 8'h6F, "stop_hold");
      checkOutput(t0 + 60, 8'h6F, "stop_hold20");
      checkOutput(t0 + 64, 8'h6F, "resume_frac");
      checkOutput(t0 + 65, 8'hBF, "resume_tick");
      checkOutput(t0 + 73, 8'h06, "stop_again");
      checkOutput(t0 + 74, 8'h40, "clear_idle");
      gotoCycle(t0 + 36);
      press(1'b1, 1'b0);
      gotoCycle(t0 + 60);
      press(1'b1, 1'b0);
      gotoCycle(t0 + 66);
      press(1'b1, 1'b0);
      gotoCycle(t0 + 70);
      press(1'b0, 1'b1);

      gotoCycle(t0 + 78);
      doReset();
      gotoCycle(cyc + 3);
      applyStimulus(1'b0, 1'b0, 2'b11);
      startRun(t0);
      checkOutput(t0 + 14397, 8'hED, "m10_five");
      checkOutput(t0 + 14400, 8'h6D, "last_run");
      checkOutput(t0 + 14401, 8'hF1, "full");
      checkOutput(t0 + 14410, 8'hF1, "full_ignores_ss");
      checkOutput(t0 + 14414, 8'h40, "full_clear");
      gotoCycle(t0 + 14402);
      press(1'b1, 1'b0);
      gotoCycle(t0 + 14410);
      press(1'b0, 1'b1);

      gotoCycle(t0 + 14418);
      doReset();
      gotoCycle(cyc + 3);
      startRun(t0);
      checkOutput(t0 + 12, 8'h5B, "pre_both");
      checkOutput(t0 + 13, 8'h4F, "both_stop");
      checkOutput(t0 + 14, 8'h4F, "both_stop2");
      checkOutput(t0 + 15, 8'h4F, "both_stop3");
      checkOutput(t0 + 16, 8'h4F, "both_stop4");
      checkOutput(t0 + 25, 8'h4F, "both_hold");
      checkOutput(t0 + 30, 8'hCF, "resume_run");
      gotoCycle(t0 + 9);
      press(1'b1, 1'b1);
      gotoCycle(t0 + 26);
      press(1'b1, 1'b0);
      gotoCycle(t0 + 31);
      doReset();
      gotoCycle(t0 + 35);
      startRun(t0);
      checkOutput(t0 + 1, 8'hBF, "post_reset_zero");
      checkOutput(t0 + 5, 8'h86, "post_reset_one");

      waitCycles = 0;
      while (sb.size() > 0 && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      while (sb.size() > 0) begin
         monEntry = sb.pop_front();
         checkCount++;
         $display("[TB] FAIL %s: never compared, required %02h at edge %0d",
                  monEntry.name, monEntry.exp, monEntry.due);
      end
      if (passCount == checkCount && checkCount >= 12)
         $display("[TB] PASS all checks");
      else
         $display("[TB] FAIL summary: %0d of %0d checks passed", passCount, checkCount);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Watchdog against a hung simulation.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/yubex_stopwatch.md
# yubex_stopwatch

Tiny stopwatch tile: counts elapsed time up from 00:00 after a start press, supports stop/resume, lap freeze and clear, and shows one selectable BCD digit on a single 7-segment display. It is the count-up companion to the team's countdown egg timer and uses the same 8-in/8-out tile pinout with the same display encoding.

## Interface
Parameters:
- CLK_FREQ, 10000: clock frequency in Hz; prescaler terminal count is CLK_FREQ-1; must be ≥ 2 and fit in 14 bits.

Ports (clock and reset carried on io_in as in every tile):
- io_in[0] (clk)  input  1  single clock, all state updates on its rising edge.
- io_in[1] (rst)  input  1  synchronous, active-high reset.
- io_in[2] (start_stop)  input  1  button, asynchronous level; rising edge toggles run/stop.
- io_in[3] (lap_clr)  input  1  button, asynchronous level; rising edge = lap or clear.
- io_in[5:4] (digit_sel)  input  2  00 sec ones, 01 sec tens, 10 min ones, 11 min tens.
- io_in[7:6]  input  2  unused, ignored.
- io_out[6:0]  output  7  segments, bit0=a … bit6=g, active-high.
- io_out[7]  output  1  decimal point / status.

## Operation
- Buttons: each passes a 2-flop synchronizer plus previous-value flop; pulse = sync2 & ~prev. Levels held high produce one pulse only.
- Time: four BCD counters s1 (0–9), s10 (0–5), m1 (0–9), m10 (0–5); advance by one second on prescaler tick with ripple carry.
- Prescaler: 14 bits, counts 0..CLK_FREQ-1 in RUN and LAP; tick when value = CLK_FREQ-1, then wraps to 0. Holds in STOP; cleared in IDLE.
- States:
  - IDLE: time 00:00. start_stop → RUN. lap_clr ignored.
  - RUN: counting. start_stop → STOP. lap_clr → LAP (latch current 4 digits into lap registers).
  - LAP: counting continues; display shows latched digits. start_stop → STOP. lap_clr → RUN.
  - STOP: counting frozen, prescaler fraction retained. start_stop → RUN (resume). lap_clr → IDLE (clear time and prescaler).
  - FULL: entered on tick when time = 59:59 (time saturates at 59:59, no wrap). Only lap_clr → IDLE; start_stop ignored.
- Simultaneous pulses: start_stop has priority; lap_clr pulse in same cycle is dropped.
- Tick coincident with a stop pulse: the tick is applied, then state becomes STOP.
- Display (registered): IDLE 0x40 ("-"); RUN live digit, dp=1 while prescaler < CLK_FREQ/2 (1 Hz blink); LAP latched digit, dp=1 steady; STOP live digit, dp=0; FULL 0xF1 ("F" + dp).
- Digit codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.

## Timing
- Reset (rst high at a rising edge): state IDLE, all counters, lap registers, prescaler, sync flops = 0; io_out = 0x00 at that edge, 0x40 from the following edge.
- Button high first sampled at edge N → pulse during cycle after N+1 → state change at edge N+2 → io_out reflects new state at edge N+3.
- Prescaler tick at edge T updates time at T; io_out shows new digit at T+1.
- digit_sel change sampled at edge N → io_out updated at edge N+1 (no synchronizer; static-select use only).
- Reset mid-RUN/LAP/FULL: same as power-on reset, no partial state kept.

## Configuration
- YUBEX_STOPWATCH_LAP_EN defined: LAP state and lap registers present as above.
- Not defined: no lap registers, no LAP state; lap_clr pulse in RUN is ignored; lap_clr still clears from STOP and FULL.

## Structure
- Package yubex_stopwatch_pkg: state encoding (IDLE, RUN, LAP, STOP, FULL, 3 bits), digit segment constants, IDLE/FULL display constants, CLK_FREQ default.
- Sub-module yubex_seg7_decoder: combinational 4-bit BCD → 7-segment; values 10–15 decode to 0x00.
- Top holds synchronizers, FSM, prescaler, BCD chain, lap latch, output register.

## Test plan (CLK_FREQ=4)
- Reset, no buttons → io_out 0x40; start_stop pulse → after 4 ticks' worth (16 cycles) with digit_sel=00 io_out[6:0]=0x66 ("4"), dp toggling every 2 cycles.
- Run to 00:09, next tick → s1=0, s10=1; digit_sel=01 shows 0x06.
- RUN at 00:05, lap_clr → display frozen at 0x6D dp=1 while live count reaches 00:08; lap_clr → display 0x7F; start_stop → STOP, dp=0, count holds 20 cycles; lap_clr → 0x40.
- Preload/run to 59:59, tick → FULL, io_out 0xF1; start_stop ignored; lap_clr → 0x40.
- start_stop and lap_clr rising same cycle in RUN → STOP, no lap latch; rst asserted mid-RUN → io_out 0x00 then 0x40, time 00:00.
- Build without YUBEX_STOPWATCH_LAP_EN: lap_clr in RUN leaves state RUN and display live.
